// File: rtl/sync_fifo_pkg.sv
// rtl/sync_fifo_pkg.sv - shared FIFO constants and sizing helpers
package sync_fifo_pkg;

    // Read-mode selectors, common to the single- and dual-clock FIFOs
    localparam int FWFT_STD  = 0;
    localparam int FWFT_FALL = 1;

    // Ceiling log2, used to size memory addresses from a word count
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Word count of a FIFO addressed by addr_width bits
    function automatic int depth_of(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// rtl/sync_fifo_if.sv - write/read/status bundle between a FIFO and its user
interface sync_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) ();

    logic                  i_w_inc;
    logic [DATA_WIDTH-1:0] i_wr_data;
    logic                  i_r_inc;
    logic                  i_err_clr;
    logic [DATA_WIDTH-1:0] o_rd_data;
    logic                  o_rd_valid;
    logic                  o_full;
    logic                  o_empty;
    logic                  o_almost_full;
    logic                  o_almost_empty;
    logic [ADDR_WIDTH:0]   o_level;
    logic                  o_overflow;
    logic                  o_underflow;

    // FIFO user: issues requests, observes data and status
    modport master (
        output i_w_inc, i_wr_data, i_r_inc, i_err_clr,
        input  o_rd_data, o_rd_valid, o_full, o_empty, o_almost_full,
               o_almost_empty, o_level, o_overflow, o_underflow
    );

    // FIFO itself
    modport slave (
        input  i_w_inc, i_wr_data, i_r_inc, i_err_clr,
        output o_rd_data, o_rd_valid, o_full, o_empty, o_almost_full,
               o_almost_empty, o_level, o_overflow, o_underflow
    );

endinterface

// File: rtl/sync_fifo_mem.sv
// rtl/sync_fifo_mem.sv - register-array storage, one write port, one async read port
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                     i_clk,
    input  logic                     i_wr_en,
    input  logic [clog2(DEPTH)-1:0]  i_waddr,
    input  logic [DATA_WIDTH-1:0]    i_wr_data,
    input  logic [clog2(DEPTH)-1:0]  i_raddr,
    output logic [DATA_WIDTH-1:0]    o_rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Storage is deliberately not reset; pointers define what is valid
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            mem[i_waddr] <= i_wr_data;
        end
    end

    assign o_rd_data = mem[i_raddr];

endmodule

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with level, thresholds, FWFT option; SYNC_FIFO_ERR_EN enables sticky error flags
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_THRESH  = 14,
    parameter int AE_THRESH  = 2,
    parameter int FWFT       = FWFT_STD
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    sync_fifo_if.slave bus
);

    localparam int                DEPTH   = depth_of(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_L    = (ADDR_WIDTH + 1)'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0] AE_L    = (ADDR_WIDTH + 1)'(AE_THRESH);

    // Extra top bit distinguishes full from empty when addresses coincide
    logic [ADDR_WIDTH:0]   wptr;
    logic [ADDR_WIDTH:0]   rptr;
    logic [ADDR_WIDTH:0]   level;
    logic                  full;
    logic                  empty;
    logic                  wr_acc;
    logic                  rd_acc;
    logic [DATA_WIDTH-1:0] mem_rdata;

    assign level  = wptr - rptr;
    assign full   = (level == DEPTH_L);
    assign empty  = (level == '0);
    assign wr_acc = bus.i_w_inc & ~full;
    assign rd_acc = bus.i_r_inc & ~empty;

    assign bus.o_level        = level;
    assign bus.o_full         = full;
    assign bus.o_empty        = empty;
    assign bus.o_almost_full  = (level >= AF_L);
    assign bus.o_almost_empty = (level <= AE_L);

    // Pointer counters; rejected requests leave them untouched
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_acc) wptr <= wptr + 1'b1;
            if (rd_acc) rptr <= rptr + 1'b1;
        end
    end

    sync_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .i_clk     (i_clk),
        .i_wr_en   (wr_acc),
        .i_waddr   (wptr[ADDR_WIDTH-1:0]),
        .i_wr_data (bus.i_wr_data),
        .i_raddr   (rptr[ADDR_WIDTH-1:0]),
        .o_rd_data (mem_rdata)
    );

    generate
        if (FWFT == FWFT_STD) begin : g_std
            logic [DATA_WIDTH-1:0] rd_data_q;
            logic                  rd_valid_q;

            // Registered read: capture head on pop, valid for one cycle, data held after
            always_ff @(posedge i_clk) begin
                if (!i_rst_n) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_acc;
                    if (rd_acc) rd_data_q <= mem_rdata;
                end
            end

            assign bus.o_rd_data  = rd_data_q;
            assign bus.o_rd_valid = rd_valid_q;
        end else begin : g_fwft
            // Head word shown directly; zero while empty so stale storage never leaks out
            assign bus.o_rd_data  = empty ? '0 : mem_rdata;
            assign bus.o_rd_valid = ~empty;
        end
    endgenerate

`ifdef SYNC_FIFO_ERR_EN
    logic overflow_q;
    logic underflow_q;

    // Sticky error flags; a new error in the clearing cycle keeps the flag set
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (bus.i_w_inc & full)        overflow_q <= 1'b1;
            else if (bus.i_err_clr)        overflow_q <= 1'b0;
            if (bus.i_r_inc & empty)       underflow_q <= 1'b1;
            else if (bus.i_err_clr)        underflow_q <= 1'b0;
        end
    end

    assign bus.o_overflow  = overflow_q;
    assign bus.o_underflow = underflow_q;
`else
    logic unused_err_clr;
    assign unused_err_clr  = bus.i_err_clr;
    assign bus.o_overflow  = 1'b0;
    assign bus.o_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// tb/tb_sync_fifo.sv - directed scoreboard bench for sync_fifo in registered and FWFT modes
module tb_sync_fifo;

`ifdef SYNC_FIFO_ERR_EN
    localparam logic ERR = 1'b1;
`else
    localparam logic ERR = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    logic [7:0] sb [$];
    logic [7:0] exp_data;
    logic [7:0] last_data;

    sync_fifo_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus_std ();
    sync_fifo_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus_ft ();

    sync_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .AF_THRESH(14), .AE_THRESH(2), .FWFT(0)) dut_std (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus_std)
    );

    sync_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .AF_THRESH(14), .AE_THRESH(2), .FWFT(1)) dut_ft (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus_ft)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_std(input string tag);
        chk({tag, "_level"},  32'(bus_std.o_level), 0);
        chk({tag, "_empty"},  32'(bus_std.o_empty), 1);
        chk({tag, "_ae"},     32'(bus_std.o_almost_empty), 1);
        chk({tag, "_full"},   32'(bus_std.o_full), 0);
        chk({tag, "_af"},     32'(bus_std.o_almost_full), 0);
        chk({tag, "_rdata"},  32'(bus_std.o_rd_data), 0);
        chk({tag, "_rvalid"}, 32'(bus_std.o_rd_valid), 0);
        chk({tag, "_ovf"},    32'(bus_std.o_overflow), 0);
        chk({tag, "_unf"},    32'(bus_std.o_underflow), 0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus_std.i_w_inc = 1'b0; bus_std.i_wr_data = '0; bus_std.i_r_inc = 1'b0; bus_std.i_err_clr = 1'b0;
        bus_ft.i_w_inc  = 1'b0; bus_ft.i_wr_data  = '0; bus_ft.i_r_inc  = 1'b0; bus_ft.i_err_clr  = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        chk_reset_std("rst");
        chk("rst_ft_rvalid", 32'(bus_ft.o_rd_valid), 0);
        chk("rst_ft_rdata", 32'(bus_ft.o_rd_data), 0);

        // Fill to full, thresholds tracked against the written count
        for (int i = 0; i < 16; i++) begin
            bus_std.i_w_inc = 1'b1;
            bus_std.i_wr_data = 8'(i);
            sb.push_back(8'(i));
            tick();
            chk($sformatf("fill_level_%0d", i), 32'(bus_std.o_level), 32'(i + 1));
            chk($sformatf("fill_af_%0d", i), 32'(bus_std.o_almost_full), 32'((i + 1) >= 14));
            chk($sformatf("fill_ae_%0d", i), 32'(bus_std.o_almost_empty), 32'((i + 1) <= 2));
        end
        chk("full_flag", 32'(bus_std.o_full), 1);
        bus_std.i_wr_data = 8'hEE;
        tick();
        bus_std.i_w_inc = 1'b0;
        chk("drop_level", 32'(bus_std.o_level), 16);
        chk("drop_full", 32'(bus_std.o_full), 1);
        chk("overflow", 32'(bus_std.o_overflow), 32'(ERR));

        // Drain in order, one-cycle registered read latency
        for (int i = 0; i < 16; i++) begin
            bus_std.i_r_inc = 1'b1;
            tick();
            exp_data = sb.pop_front();
            chk($sformatf("drain_valid_%0d", i), 32'(bus_std.o_rd_valid), 1);
            chk($sformatf("drain_data_%0d", i), 32'(bus_std.o_rd_data), 32'(exp_data));
            last_data = exp_data;
        end
        bus_std.i_r_inc = 1'b0;
        tick();
        chk("drain_empty", 32'(bus_std.o_empty), 1);
        chk("drain_valid_off", 32'(bus_std.o_rd_valid), 0);
        chk("drain_hold", 32'(bus_std.o_rd_data), 32'(last_data));
        chk("ovf_sticky", 32'(bus_std.o_overflow), 32'(ERR));

        // Read while empty ignored; error flags sticky until cleared
        bus_std.i_r_inc = 1'b1;
        tick();
        bus_std.i_r_inc = 1'b0;
        chk("unf_level", 32'(bus_std.o_level), 0);
        chk("unf_valid", 32'(bus_std.o_rd_valid), 0);
        chk("underflow", 32'(bus_std.o_underflow), 32'(ERR));
        tick();
        chk("unf_sticky", 32'(bus_std.o_underflow), 32'(ERR));
        bus_std.i_err_clr = 1'b1;
        tick();
        chk("clr_ovf", 32'(bus_std.o_overflow), 0);
        chk("clr_unf", 32'(bus_std.o_underflow), 0);
        bus_std.i_r_inc = 1'b1;
        tick();
        bus_std.i_r_inc = 1'b0;
        chk("set_beats_clr", 32'(bus_std.o_underflow), 32'(ERR));
        tick();
        bus_std.i_err_clr = 1'b0;
        chk("clr_again", 32'(bus_std.o_underflow), 0);

        // Level 5 then concurrent write+read across the pointer wrap
        for (int i = 0; i < 5; i++) begin
            bus_std.i_w_inc = 1'b1;
            bus_std.i_wr_data = 8'(8'h20 + i);
            sb.push_back(8'(8'h20 + i));
            tick();
        end
        chk("lvl5", 32'(bus_std.o_level), 5);
        bus_std.i_r_inc = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus_std.i_wr_data = 8'(8'h30 + i);
            sb.push_back(8'(8'h30 + i));
            tick();
            exp_data = sb.pop_front();
            chk($sformatf("rw_level_%0d", i), 32'(bus_std.o_level), 5);
            chk($sformatf("rw_valid_%0d", i), 32'(bus_std.o_rd_valid), 1);
            chk($sformatf("rw_data_%0d", i), 32'(bus_std.o_rd_data), 32'(exp_data));
        end
        bus_std.i_w_inc = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            exp_data = sb.pop_front();
            chk($sformatf("rw_tail_%0d", i), 32'(bus_std.o_rd_data), 32'(exp_data));
        end
        bus_std.i_r_inc = 1'b0;
        tick();
        chk("rw_empty", 32'(bus_std.o_empty), 1);

        // First-word-fall-through: written word appears without a read
        chk("ft_pre_valid", 32'(bus_ft.o_rd_valid), 0);
        bus_ft.i_w_inc = 1'b1;
        bus_ft.i_wr_data = 8'hA5;
        tick();
        bus_ft.i_w_inc = 1'b0;
        chk("ft_data", 32'(bus_ft.o_rd_data), 32'h A5);
        chk("ft_valid", 32'(bus_ft.o_rd_valid), 1);
        chk("ft_level", 32'(bus_ft.o_level), 1);
        bus_ft.i_r_inc = 1'b1;
        tick();
        bus_ft.i_r_inc = 1'b0;
        chk("ft_pop_empty", 32'(bus_ft.o_empty), 1);
        chk("ft_pop_valid", 32'(bus_ft.o_rd_valid), 0);

        // Reset mid-operation at level 9 discards everything
        bus_std.i_w_inc = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus_std.i_wr_data = 8'(8'h50 + i);
            tick();
        end
        bus_std.i_w_inc = 1'b0;
        bus_std.i_r_inc = 1'b1;
        tick();
        bus_std.i_r_inc = 1'b0;
        chk("pre_rst_level", 32'(bus_std.o_level), 9);
        chk("pre_rst_valid", 32'(bus_std.o_rd_valid), 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_reset_std("midrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
